ps2_mouse_decoder: RTL and testbench



---
 rtl/ps2_mouse_decoder.sv | 225 ++++++++++++++++++++++
 tb/tb_ps2_mouse_decoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_mouse_decoder
// Brief    : PS/2 mouse receiver, 3-byte stream packets -> clamped cursor/buttons
// Revision : 1.0 - initial release
// ============================================================================
module ps2_mouse_decoder #(
    parameter int MAX_X          = 1023,
    parameter int MAX_Y          = 767,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [11:0] mouse_x,
    output logic [11:0] mouse_y,
    output logic        mouse_left,
    output logic        mouse_right,
    output logic        mouse_clicked,
    output logic        packet_valid,
    output logic        frame_error
);

    localparam int c_FILT_W = $clog2(FILTER_LEN + 1);
    localparam int c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_FILT_W-1:0] c_FILT_LAST = c_FILT_W'(FILTER_LEN - 1);
    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic signed [13:0]  c_MAX_X_S   = 14'(MAX_X);
    localparam logic signed [13:0]  c_MAX_Y_S   = 14'(MAX_Y);
    localparam logic [11:0]         c_MAX_X12   = 12'(MAX_X);
    localparam logic [11:0]         c_MAX_Y12   = 12'(MAX_Y);
    localparam logic [11:0]         c_X_RST     = 12'(MAX_X / 2);
    localparam logic [11:0]         c_Y_RST     = 12'(MAX_Y / 2);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} bit_state_t;
    typedef enum logic [1:0] {P_BYTE0, P_BYTE1, P_BYTE2} pkt_state_t;

    logic                r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic                r_clk_filt, r_clk_filt_d;
    logic [c_FILT_W-1:0] r_filt_cnt;
    logic                w_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1     <= 1'b1;
            r_clk_s2     <= 1'b1;
            r_dat_s1     <= 1'b1;
            r_dat_s2     <= 1'b1;
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
            r_filt_cnt   <= '0;
        end else begin
            r_clk_s1     <= ps2_clk;
            r_clk_s2     <= r_clk_s1;
            r_dat_s1     <= ps2_data;
            r_dat_s2     <= r_dat_s1;
            r_clk_filt_d <= r_clk_filt;
            // Filtered clock follows only after FILTER_LEN consecutive differing samples
            if (r_clk_s2 != r_clk_filt) begin
                if (r_filt_cnt == c_FILT_LAST) begin
                    r_clk_filt <= r_clk_s2;
                    r_filt_cnt <= '0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + c_FILT_W'(1);
                end
            end else begin
                r_filt_cnt <= '0;
            end
        end
    end

    assign w_fall = r_clk_filt_d & ~r_clk_filt;

    bit_state_t          r_bstate, w_bstate_nxt;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic                r_par;
    logic [c_TO_W-1:0]   r_wdog;
    logic                w_timeout, w_byte_done, w_stop_err, w_frame_err;
    logic                r_frame_err;

    assign w_timeout   = (r_bstate != S_IDLE) && !w_fall && (r_wdog >= c_TO_LAST);
    assign w_frame_err = w_stop_err | w_timeout;

    always_ff @(posedge clk) begin
        if (rst) r_bstate <= S_IDLE;
        else     r_bstate <= w_bstate_nxt;
    end

    always_comb begin
        w_bstate_nxt = r_bstate;
        w_byte_done  = 1'b0;
        w_stop_err   = 1'b0;
        if (w_timeout) begin
            w_bstate_nxt = S_IDLE;
        end else if (w_fall) begin
            case (r_bstate)
                S_IDLE:   if (!r_dat_s2) w_bstate_nxt = S_DATA;
                S_DATA:   if (r_bit_cnt == 3'd7) w_bstate_nxt = S_PARITY;
                S_PARITY: w_bstate_nxt = S_STOP;
                S_STOP: begin
                    if (r_dat_s2 && (^{r_shift, r_par})) w_byte_done = 1'b1;
                    else                                 w_stop_err  = 1'b1;
                    w_bstate_nxt = S_IDLE;
                end
                default:  w_bstate_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_wdog      <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            if (r_bstate == S_IDLE || w_fall || w_timeout) r_wdog <= '0;
            else                                           r_wdog <= r_wdog + c_TO_W'(1);
            if (w_fall) begin
                case (r_bstate)
                    S_IDLE:   r_bit_cnt <= '0;
                    S_DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    S_PARITY: r_par <= r_dat_s2;
                    default:  ;
                endcase
            end
        end
    end

    // Header fields kept: {Yovf, Xovf, Ysign, Xsign, R, L}
    pkt_state_t          r_pstate, w_pstate_nxt;
    logic [5:0]          r_hdr;
    logic [7:0]          r_b1;
    logic                w_commit;
    logic signed [13:0]  w_dx, w_dy, w_sum_x, w_sum_y;
    logic [11:0]         w_new_x, w_new_y;
    logic [11:0]         r_x, r_y;
    logic                r_left, r_right, r_clicked, r_pkt_valid;

    always_ff @(posedge clk) begin
        if (rst) r_pstate <= P_BYTE0;
        else     r_pstate <= w_pstate_nxt;
    end

    always_comb begin
        w_pstate_nxt = r_pstate;
        w_commit     = 1'b0;
        if (w_frame_err) begin
            w_pstate_nxt = P_BYTE0;
        end else if (w_byte_done) begin
            case (r_pstate)
                P_BYTE0: if (r_shift[3]) w_pstate_nxt = P_BYTE1;
                P_BYTE1: w_pstate_nxt = P_BYTE2;
                P_BYTE2: begin
                    w_pstate_nxt = P_BYTE0;
                    w_commit     = 1'b1;
                end
                default: w_pstate_nxt = P_BYTE0;
            endcase
        end
    end

    assign w_dx    = {{5{r_hdr[2]}}, r_hdr[2], r_b1};
    assign w_dy    = {{5{r_hdr[3]}}, r_hdr[3], r_shift};
    assign w_sum_x = $signed({2'b00, r_x}) + w_dx;
    assign w_sum_y = $signed({2'b00, r_y}) - w_dy;

    always_comb begin
        if (w_sum_x < 14'sd0)          w_new_x = '0;
        else if (w_sum_x > c_MAX_X_S)  w_new_x = c_MAX_X12;
        else                           w_new_x = w_sum_x[11:0];
        if (w_sum_y < 14'sd0)          w_new_y = '0;
        else if (w_sum_y > c_MAX_Y_S)  w_new_y = c_MAX_Y12;
        else                           w_new_y = w_sum_y[11:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hdr       <= '0;
            r_b1        <= '0;
            r_x         <= c_X_RST;
            r_y         <= c_Y_RST;
            r_left      <= 1'b0;
            r_right     <= 1'b0;
            r_clicked   <= 1'b0;
            r_pkt_valid <= 1'b0;
        end else begin
            r_clicked   <= 1'b0;
            r_pkt_valid <= 1'b0;
            if (w_byte_done && !w_frame_err) begin
                if (r_pstate == P_BYTE0 && r_shift[3])
                    r_hdr <= {r_shift[7:4], r_shift[1:0]};
                if (r_pstate == P_BYTE1)
                    r_b1 <= r_shift;
            end
            if (w_commit) begin
                if (!r_hdr[4]) r_x <= w_new_x;
                if (!r_hdr[5]) r_y <= w_new_y;
                r_left      <= r_hdr[0];
                r_right     <= r_hdr[1];
                r_clicked   <= r_hdr[0] & ~r_left;
                r_pkt_valid <= 1'b1;
            end
        end
    end

    assign mouse_x       = r_x;
    assign mouse_y       = r_y;
    assign mouse_left    = r_left;
    assign mouse_right   = r_right;
    assign mouse_clicked = r_clicked;
    assign packet_valid  = r_pkt_valid;
    assign frame_error   = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_mouse_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ps2_mouse_decoder
// Brief    : Scoreboard bench: directed PS/2 frames, monitor checks every event
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_mouse_decoder;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 2000;
    localparam int HALF       = 16;
    localparam int GAP        = 30;
    localparam int LAT        = 2 + FILTER_LEN + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [11:0] mouse_x, mouse_y;
    logic        mouse_left, mouse_right, mouse_clicked, packet_valid, frame_error;

    ps2_mouse_decoder #(
        .MAX_X(1023), .MAX_Y(767), .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_left(mouse_left),
        .mouse_right(mouse_right), .mouse_clicked(mouse_clicked),
        .packet_valid(packet_valid), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 = packet, 1 = frame error
        int x;
        int y;
        int l;
        int r;
        int c;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mouse_clicked && !packet_valid) chk("stray_click", 1, 0);
            if (packet_valid || frame_error) begin
                chk("pv_fe_exclusive", int'(packet_valid & frame_error), 0);
                if (q.size() == 0) begin
                    chk("unexpected_event", int'({packet_valid, frame_error}), 0);
                end else begin
                    automatic exp_t e = q.pop_front();
                    chk("event_kind", frame_error ? 1 : 0, e.kind);
                    if (e.kind == 0 && packet_valid) begin
                        chk("mouse_x", int'(mouse_x), e.x);
                        chk("mouse_y", int'(mouse_y), e.y);
                        chk("mouse_left", int'(mouse_left), e.l);
                        chk("mouse_right", int'(mouse_right), e.r);
                        chk("mouse_clicked", int'(mouse_clicked), e.c);
                        chk("latency", cyc - last_fall_cyc, LAT);
                    end
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            wait_clk(5);
            ps2_clk = 1'b0;
            wait_clk(2);
            ps2_clk = 1'b1;
            wait_clk(HALF - 7);
        end else begin
            wait_clk(HALF);
        end
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        wait_clk(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit glitch);
        logic p;
        p = ~(^b);
        if (bad_par) p = ~p;
        send_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
        send_bit(p, glitch);
        send_bit(1'b1, glitch);
        ps2_data = 1'b1;
        wait_clk(GAP);
    endtask

    task automatic expect_pkt(input int x, input int y, input int l, input int r, input int c);
        exp_t e;
        e.kind = 0; e.x = x; e.y = y; e.l = l; e.r = r; e.c = c;
        q.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        e.kind = 1; e.x = 0; e.y = 0; e.l = 0; e.r = 0; e.c = 0;
        q.push_back(e);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input bit glitch);
        send_byte(b0, 1'b0, glitch);
        send_byte(b1, 1'b0, glitch);
        send_byte(b2, 1'b0, glitch);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 1000) begin
            wait_clk(1);
            n++;
        end
        chk("queue_drained", q.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_x"}, int'(mouse_x), 511);
        chk({tag, "_y"}, int'(mouse_y), 383);
        chk({tag, "_left"}, int'(mouse_left), 0);
        chk({tag, "_right"}, int'(mouse_right), 0);
        chk({tag, "_clicked"}, int'(mouse_clicked), 0);
        chk({tag, "_pv"}, int'(packet_valid), 0);
        chk({tag, "_fe"}, int'(frame_error), 0);
    endtask

    task automatic do_reset(input string tag);
        drain();
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(2);
        check_reset_state(tag);
    endtask

    initial begin
        int sat_tab[9];
        sat_tab = '{127, 254, 381, 508, 635, 762, 889, 1016, 1023};

        do_reset("rst0");

        // Basic move: +10 X, +5 Y (screen Y goes up by 5)
        expect_pkt(521, 378, 0, 0, 0);
        send_pkt(8'h08, 8'h0A, 8'h05, 1'b0);

        // Click sequence: press, hold, release, press
        expect_pkt(521, 378, 1, 0, 1); send_pkt(8'h09, 8'h00, 8'h00, 1'b0);
        expect_pkt(521, 378, 1, 0, 0); send_pkt(8'h09, 8'h00, 8'h00, 1'b0);
        expect_pkt(521, 378, 0, 0, 0); send_pkt(8'h08, 8'h00, 8'h00, 1'b0);
        expect_pkt(521, 378, 1, 0, 1); send_pkt(8'h09, 8'h00, 8'h00, 1'b0);

        // X clamping at both ends
        do_reset("rst1");
        expect_pkt(255, 383, 0, 0, 0); send_pkt(8'h18, 8'h00, 8'h00, 1'b0);
        expect_pkt(0,   383, 0, 0, 0); send_pkt(8'h18, 8'h00, 8'h00, 1'b0);
        expect_pkt(0,   383, 0, 0, 0); send_pkt(8'h18, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 9; i++) begin
            expect_pkt(sat_tab[i], 383, 0, 0, 0);
            send_pkt(8'h08, 8'h7F, 8'h00, 1'b0);
        end

        // X overflow flag freezes X, Y and buttons still update
        do_reset("rst2");
        expect_pkt(511, 351, 1, 0, 1);
        send_pkt(8'h49, 8'h40, 8'h20, 1'b0);

        // Bad parity on byte 2, then a clean packet
        send_byte(8'h08, 1'b0, 1'b0);
        expect_err();
        send_byte(8'h10, 1'b1, 1'b0);
        expect_pkt(521, 346, 0, 0, 0);
        send_pkt(8'h08, 8'h0A, 8'h05, 1'b0);

        // Header without bit3 is dropped silently
        send_byte(8'h00, 1'b0, 1'b0);
        expect_pkt(526, 346, 0, 0, 0);
        send_pkt(8'h08, 8'h05, 8'h00, 1'b0);

        // Clock stalls after start + 5 data bits
        expect_err();
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        ps2_data = 1'b1;
        wait_clk(TIMEOUT + 100);
        chk("timeout_seen", q.size(), 0);
        expect_pkt(526, 336, 0, 0, 0);
        send_pkt(8'h08, 8'h00, 8'h0A, 1'b0);

        // Short clock glitches must not create bits
        expect_pkt(529, 83, 1, 0, 1);
        send_pkt(8'h09, 8'h03, 8'hFD, 1'b1);

        // Y clamping: below 0, then above MAX_Y; right button
        expect_pkt(529, 0,   0, 1, 0); send_pkt(8'h0A, 8'h00, 8'h7F, 1'b0);
        expect_pkt(529, 255, 0, 0, 0); send_pkt(8'h28, 8'h00, 8'h01, 1'b0);
        expect_pkt(529, 511, 0, 0, 0); send_pkt(8'h28, 8'h00, 8'h00, 1'b0);
        expect_pkt(529, 767, 0, 0, 0); send_pkt(8'h28, 8'h00, 8'h00, 1'b0);
        expect_pkt(529, 767, 0, 0, 0); send_pkt(8'h28, 8'h00, 8'h00, 1'b0);

        // Reset in the middle of byte 2 of a packet
        send_byte(8'h09, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        do_reset("rst_mid");
        wait_clk(GAP);
        expect_pkt(521, 378, 0, 0, 0);
        send_pkt(8'h08, 8'h0A, 8'h05, 1'b0);

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not complete, got %0d events pending required 0", q.size());
        $fatal(1);
    end

endmodule
`default_nettype wire
